// File: rtl/lcd_hien_thi_20x4.sv
// lcd_hien_thi_20x4: refreshes a 20x4 HD44780 character LCD (8-bit, write-only)
// from four 160-bit line buffers, snapshotted once per frame.
// Ports: clk, rst_n (async active-low); lcd_h0..lcd_h3 line text (char 0 in [159:152]);
//        lcd_rs/lcd_rw/lcd_en/lcd_data LCD bus; lcd_on power enable;
//        frame_done pulses in the final wait cycle of each frame.
module lcd_hien_thi_20x4 #(
    parameter int unsigned T_POWERUP = 1000000,
    parameter int unsigned T_SETUP   = 5,
    parameter int unsigned T_EN      = 25,
    parameter int unsigned T_CMD     = 2500,
    parameter int unsigned T_CLEAR   = 100000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [159:0] lcd_h0,
    input  logic [159:0] lcd_h1,
    input  logic [159:0] lcd_h2,
    input  logic [159:0] lcd_h3,
    output logic         lcd_rs,
    output logic         lcd_rw,
    output logic         lcd_en,
    output logic [7:0]   lcd_data,
    output logic         lcd_on,
    output logic         frame_done
);
    localparam int unsigned M1 = (T_POWERUP > T_CLEAR) ? T_POWERUP : T_CLEAR;
    localparam int unsigned M2 = (M1 > T_CMD) ? M1 : T_CMD;
    localparam int unsigned M3 = (M2 > T_EN) ? M2 : T_EN;
    localparam int unsigned MX = (M3 > T_SETUP) ? M3 : T_SETUP;
    localparam int CW = $clog2(MX + 1);

    typedef enum logic [2:0] {
        PWR_WAIT, INIT, SNAP, LINE_ADDR, CHARS
    } top_t;
    typedef enum logic [1:0] {
        PH_SETUP, PH_EN, PH_WAIT
    } ph_t;

    top_t st, st_n;
    ph_t ph, ph_n;
    logic [CW-1:0] cnt, cnt_n, lim;
    logic [1:0] idx, idx_n, line, line_n;
    logic [4:0] col, col_n;
    logic [0:3][159:0] fbuf;
    logic snap_en, byte_st, is_clear, byte_done;
    logic [159:0] sel, shl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st     <= PWR_WAIT;
            ph     <= PH_SETUP;
            cnt    <= '0;
            idx    <= '0;
            line   <= '0;
            col    <= '0;
            fbuf   <= '0;
            lcd_on <= 1'b0;
        end else begin
            st     <= st_n;
            ph     <= ph_n;
            cnt    <= cnt_n;
            idx    <= idx_n;
            line   <= line_n;
            col    <= col_n;
            lcd_on <= 1'b1;
            if (snap_en)
                fbuf <= {lcd_h0, lcd_h1, lcd_h2, lcd_h3};
        end
    end

    // Clear display needs the long wait; every other byte uses T_CMD.
    assign is_clear = (st == INIT) && (idx == 2'd3);
    assign byte_st  = (st == INIT) || (st == LINE_ADDR) || (st == CHARS);

    always_comb begin
        lim = CW'(T_CMD - 1);
        unique case (ph)
            PH_SETUP: lim = CW'(T_SETUP - 1);
            PH_EN:    lim = CW'(T_EN - 1);
            default:  lim = is_clear ? CW'(T_CLEAR - 1) : CW'(T_CMD - 1);
        endcase
    end

    always_comb begin
        st_n       = st;
        ph_n       = ph;
        cnt_n      = cnt + 1'b1;
        idx_n      = idx;
        line_n     = line;
        col_n      = col;
        snap_en    = 1'b0;
        byte_done  = 1'b0;
        frame_done = 1'b0;
        unique case (st)
            PWR_WAIT: begin
                if (cnt == CW'(T_POWERUP - 1)) begin
                    st_n  = INIT;
                    ph_n  = PH_SETUP;
                    cnt_n = '0;
                    idx_n = '0;
                end
            end
            SNAP: begin
                snap_en = 1'b1;
                st_n    = LINE_ADDR;
                ph_n    = PH_SETUP;
                line_n  = '0;
                cnt_n   = '0;
            end
            default: begin
                if (cnt == lim) begin
                    cnt_n = '0;
                    unique case (ph)
                        PH_SETUP: ph_n = PH_EN;
                        PH_EN:    ph_n = PH_WAIT;
                        default: begin
                            ph_n      = PH_SETUP;
                            byte_done = 1'b1;
                        end
                    endcase
                end
            end
        endcase
        if (byte_done) begin
            unique case (1'b1)
                st == INIT: begin
                    if (idx == 2'd3)
                        st_n = SNAP;
                    else
                        idx_n = idx + 1'b1;
                end
                st == LINE_ADDR: begin
                    st_n  = CHARS;
                    col_n = '0;
                end
                default: begin
                    if (col == 5'd19) begin
                        if (line == 2'd3) begin
                            frame_done = 1'b1;
                            st_n       = SNAP;
                        end else begin
                            line_n = line + 1'b1;
                            st_n   = LINE_ADDR;
                        end
                    end else begin
                        col_n = col + 1'b1;
                    end
                end
            endcase
        end
    end

    // Character select: shift the chosen line so column col lands on the top byte.
    assign sel = fbuf[line];
    assign shl = sel << {col, 3'b000};

    always_comb begin
        lcd_data = 8'h00;
        unique case (st)
            INIT: begin
                unique case (idx)
                    2'd0:    lcd_data = 8'h38;
                    2'd1:    lcd_data = 8'h0C;
                    2'd2:    lcd_data = 8'h06;
                    default: lcd_data = 8'h01;
                endcase
            end
            LINE_ADDR: begin
                unique case (line)
                    2'd0:    lcd_data = 8'h80;
                    2'd1:    lcd_data = 8'hC0;
                    2'd2:    lcd_data = 8'h94;
                    default: lcd_data = 8'hD4;
                endcase
            end
            CHARS:   lcd_data = shl[159:152];
            default: lcd_data = 8'h00;
        endcase
    end

    assign lcd_rs = (st == CHARS);
    assign lcd_rw = 1'b0;
    assign lcd_en = byte_st && (ph == PH_EN);

endmodule

// File: tb/tb_lcd_hien_thi_20x4.sv
// tb_lcd_hien_thi_20x4: directed bench for the 20x4 LCD refresher with
// shortened timing parameters.
module tb_lcd_hien_thi_20x4;
    localparam int unsigned TP = 20;
    localparam int unsigned TS = 2;
    localparam int unsigned TE = 3;
    localparam int unsigned TC = 5;
    localparam int unsigned TK = 10;

    logic clk = 1'b0;
    logic rst_n;
    logic [159:0] h0, h1, h2, h3;
    logic lcd_rs, lcd_rw, lcd_en, lcd_on, frame_done;
    logic [7:0] lcd_data;

    always #5 clk = ~clk;

    lcd_hien_thi_20x4 #(
        .T_POWERUP(TP), .T_SETUP(TS), .T_EN(TE), .T_CMD(TC), .T_CLEAR(TK)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .lcd_h0(h0), .lcd_h1(h1), .lcd_h2(h2), .lcd_h3(h3),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
        .lcd_data(lcd_data), .lcd_on(lcd_on), .frame_done(frame_done)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [8:0] sq[$];
    int rq[$], fq[$], fdq[$], fds[$];
    int rw_bad = 0, chg_bad = 0, len_bad = 0;
    logic pen = 1'b0;
    logic prs = 1'b0;
    logic [7:0] pdata = 8'h00;
    int len = 0;

    always @(posedge clk) cyc++;

    // Bus monitor: records each enable strobe and watches bus invariants.
    always @(negedge clk) begin
        if (lcd_rw !== 1'b0) rw_bad++;
        if (!rst_n) begin
            pen = 1'b0;
            len = 0;
        end else begin
            if ((pen || lcd_en) && (lcd_rs !== prs || lcd_data !== pdata))
                chg_bad++;
            if (lcd_en && !pen) begin
                sq.push_back({lcd_rs, lcd_data});
                rq.push_back(cyc);
            end
            if (lcd_en) len++;
            if (!lcd_en && pen) begin
                fq.push_back(cyc);
                if (len != TE) len_bad++;
                len = 0;
            end
            if (frame_done) begin
                fdq.push_back(cyc);
                fds.push_back(sq.size());
            end
            pen = lcd_en;
        end
        prs   = lcd_rs;
        pdata = lcd_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [159:0] s2v(input string s);
        logic [159:0] v;
        v = '0;
        for (int i = 0; i < 20; i++) v[159-8*i -: 8] = s[i];
        return v;
    endfunction

    task automatic wait_sq(input int n);
        int t;
        t = 0;
        while (sq.size() < n && t < 5000) begin
            @(posedge clk);
            t++;
        end
        chk("wait_strobes", 32'(sq.size() >= n), 32'd1);
    endtask

    task automatic wait_fd(input int n);
        int t;
        t = 0;
        while (fdq.size() < n && t < 5000) begin
            @(posedge clk);
            t++;
        end
        chk("wait_frame_done", 32'(fdq.size() >= n), 32'd1);
    endtask

    task automatic check_line(input int base, input int ln,
                              input logic [159:0] txt, input string tag);
        logic [7:0] addr[4];
        logic [8:0] got;
        addr = '{8'h80, 8'hC0, 8'h94, 8'hD4};
        got = sq[base + 21*ln];
        chk({tag, "_addr"}, 32'(got), 32'({1'b0, addr[ln]}));
        for (int c = 0; c < 20; c++) begin
            got = sq[base + 21*ln + 1 + c];
            chk($sformatf("%s_c%0d", tag, c), 32'(got),
                32'({1'b1, txt[159-8*c -: 8]}));
        end
    endtask

    task automatic count_powerup(input string tag);
        int n;
        logic on1;
        n = 0;
        on1 = 1'b0;
        while (n < 200) begin
            @(posedge clk);
            n++;
            #1;
            if (n == 1) on1 = lcd_on;
            if (lcd_en) break;
        end
        chk({tag, "_delay"}, 32'(n), 32'(TP + TS));
        chk({tag, "_on"}, 32'(on1), 32'd1);
    endtask

    task automatic check_init(input int b, input string tag);
        chk({tag, "_38"}, 32'(sq[b]),   32'h038);
        chk({tag, "_0c"}, 32'(sq[b+1]), 32'h00C);
        chk({tag, "_06"}, 32'(sq[b+2]), 32'h006);
        chk({tag, "_01"}, 32'(sq[b+3]), 32'h001);
    endtask

    logic [159:0] abc, l0, zz;
    int sb, t;

    initial begin
        l0  = s2v("  Dong Ho The Thao  ");
        abc = s2v("ABCDEFGHIJKLMNOPQRST");
        zz  = s2v("ZZZZZZZZZZZZZZZZZZZZ");
        h0 = l0;
        h1 = abc;
        h2 = abc;
        h3 = abc;
        rst_n = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_en",   32'(lcd_en),     32'd0);
        chk("rst_on",   32'(lcd_on),     32'd0);
        chk("rst_data", 32'(lcd_data),   32'd0);
        chk("rst_rs",   32'(lcd_rs),     32'd0);
        chk("rst_fd",   32'(frame_done), 32'd0);
        chk("rst_rw",   32'(lcd_rw),     32'd0);

        @(posedge clk);
        #2 rst_n = 1'b1;
        count_powerup("pwr");

        wait_sq(5);
        check_init(0, "init");
        chk("en_width", 32'(fq[0] - rq[0]), 32'(TE));
        chk("gap_cmd", 32'(rq[1] - fq[0]), 32'(TC + TS));
        chk("gap_clear", 32'(rq[4] - fq[3]), 32'(TK + 1 + TS));

        wait_fd(1);
        chk("frame1_strobes", 32'(fds[0]), 32'd88);
        check_line(4, 0, l0, "f1l0");
        check_line(4, 1, abc, "f1l1");
        check_line(4, 2, abc, "f1l2");
        check_line(4, 3, abc, "f1l3");

        wait_fd(2);
        chk("frame_period", 32'(fdq[1] - fdq[0]), 32'd841);
        chk("frame2_strobes", 32'(fds[1]), 32'd172);

        // Change line 2 while line 0 of frame 3 is being sent.
        wait_sq(4 + 168 + 11);
        h2 = zz;
        wait_fd(4);
        check_line(4 + 168, 2, abc, "f3l2_old");
        check_line(4 + 252, 2, zz, "f4l2_new");
        check_line(4 + 252, 0, l0, "f4l0");
        chk("frame4_strobes", 32'(fds[3]), 32'd340);

        // Async reset in the middle of a character strobe.
        t = 0;
        while (t < 2000) begin
            @(posedge clk);
            t++;
            #1;
            if (lcd_en && lcd_rs) break;
        end
        chk("found_char_strobe", 32'(lcd_en && lcd_rs), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_en",   32'(lcd_en),     32'd0);
        chk("arst_on",   32'(lcd_on),     32'd0);
        chk("arst_data", 32'(lcd_data),   32'd0);
        chk("arst_rs",   32'(lcd_rs),     32'd0);
        chk("arst_fd",   32'(frame_done), 32'd0);

        repeat (3) @(posedge clk);
        sb = sq.size();
        @(posedge clk);
        #2 rst_n = 1'b1;
        count_powerup("repwr");
        wait_sq(sb + 4);
        check_init(sb, "reinit");

        wait_fd(fdq.size() + 1);
        chk("rw_never_high", 32'(rw_bad), 32'd0);
        chk("bus_stable", 32'(chg_bad), 32'd0);
        chk("en_widths", 32'(len_bad), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lcd_hien_thi_20x4.md
Name: lcd_hien_thi_20x4

Overview:
- Downstream consumer of the four 160-bit LCD line buffers.
- Drives a 20x4 HD44780-compatible character LCD in 8-bit write-only mode.
- After reset it runs the power-up wait and init command sequence, then refreshes all 80 characters continuously, frame after frame.
- All four lines are snapshotted at the start of each frame, so a frame never mixes old and new text.

Parameters:
T_POWERUP, 1000000, cycles to wait after reset release before the first command (20 ms @ 50 MHz)
T_SETUP, 5, cycles with lcd_rs/lcd_data valid and lcd_en low before the enable pulse
T_EN, 25, cycles lcd_en is held high per byte
T_CMD, 2500, cycles after lcd_en falls before the next byte (normal command or character)
T_CLEAR, 100000, cycles after lcd_en falls for the clear-display command

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
lcd_h0  input  160  line 0 text, 20 ASCII chars, char 0 in [159:152]
lcd_h1  input  160  line 1 text, same packing
lcd_h2  input  160  line 2 text, same packing
lcd_h3  input  160  line 3 text, same packing
lcd_rs  output  1  0 = command, 1 = character data
lcd_rw  output  1  always 0 (write only)
lcd_en  output  1  LCD enable strobe
lcd_data  output  8  LCD data bus
lcd_on  output  1  LCD power/backlight enable
frame_done  output  1  one-cycle pulse when the last character of line 3 completes its T_CMD wait

Behaviour:
- Reset: clock and reset are as already decided, one clock `clk`, asynchronous active-low reset `rst_n`.
  - While rst_n=0 all state clears: lcd_rs=0, lcd_rw=0, lcd_en=0, lcd_data=8'h00, lcd_on=0, frame_done=0.
  - Reset asserted mid-byte or mid-frame aborts immediately; lcd_en drops to 0 asynchronously.
  - After release the full sequence restarts from the power-up wait.
- lcd_on=1 from the first clk edge after reset release. lcd_rw is constant 0.
- Byte transfer sub-sequence, identical for every byte:
  - SETUP: lcd_rs and lcd_data are driven, lcd_en=0, for T_SETUP cycles.
  - EN_HI: lcd_en=1 for T_EN cycles.
  - WAIT: lcd_en=0 for T_CMD cycles (T_CLEAR for 8'h01). lcd_rs and lcd_data hold their value through WAIT.
  - Total per byte = T_SETUP+T_EN+T_CMD cycles.
  - The next byte's SETUP begins the cycle after WAIT ends, with no gap.
- Top FSM:
  - PWR_WAIT: T_POWERUP cycles after reset release, then INIT.
  - INIT: commands with rs=0, in order 8'h38 (function set), 8'h0C (display on, cursor off), 8'h06 (entry increment), 8'h01 (clear, T_CLEAR wait). Then SNAP.
  - SNAP: exactly 1 cycle. Registers lcd_h0..lcd_h3 into a 640-bit frame buffer, then LINE_ADDR with line=0. No bus activity in this cycle.
  - LINE_ADDR: command rs=0 with DDRAM address 8'h80, 8'hC0, 8'h94, 8'hD4 for lines 0..3. Then CHARS with col=0.
  - CHARS: rs=1, data = buffer line[159-8*col -: 8], col 0..19.
    - After col 19 of lines 0..2: go to LINE_ADDR for line+1.
    - After col 19 of line 3: frame_done=1 for exactly the cycle WAIT ends, then SNAP.
  - Init is never repeated except after reset.
- Frame length = 84 bytes (4 address + 80 chars) + 1 SNAP cycle.
- Input changes during a frame are ignored until the next SNAP. A change landing exactly in the SNAP cycle is captured.
- Non-printable byte values are sent unmodified.
- All counters must be wide enough for the largest parameter. Parameters of 0 are illegal; T_SETUP, T_EN, T_CMD, T_CLEAR ≥ 1.

Test Plan:
(Bench overrides the parameters to T_POWERUP=20, T_SETUP=2, T_EN=3, T_CMD=5, T_CLEAR=10 for all scenarios.)
1. Release rst_n at cycle 0 -> lcd_en stays 0 for 20+2 cycles. The first en-high window is 3 cycles with rs=0, data=8'h38. The four init bytes are 38, 0C, 06, 01, and the gap after 01 is 10 cycles.
2. Drive lcd_h0="  Dong Ho The Thao  ", other lines "ABCDEFGHIJKLMNOPQRST" -> the captured en-high sequence is 80, 20, 20, 44, 6F…; C0, 41…54; 94, 41…; D4, 41…54. Exactly 84 strobes per frame, then frame_done pulses once.
3. Frame period check -> successive frame_done pulses are exactly 84*10+1 = 841 cycles apart.
4. Change lcd_h2 to all 'Z' midway through line 0 of frame N -> frame N shows the old line 2 text; frame N+1 shows 5A×20 after address 94.
5. Assert rst_n=0 while lcd_en=1 during a CHARS byte -> lcd_en=0, lcd_on=0, lcd_data=00 immediately without a clk edge. After release, the 20-cycle power-up wait and init 38/0C/06/01 repeat.
6. Throughout all scenarios -> lcd_rw is never 1, and lcd_rs/lcd_data never change while lcd_en=1 or in the cycle lcd_en falls.
